// File: rtl/seq_gen_pkg.sv
// ---------------------------------------------------------------------------
// seq_gen_pkg
// Shared definitions for the serial pattern generator:
//   - PAT_W_DEF : default pattern register width
//   - state_t   : FSM state encoding for seq_pattern_gen
// Optional feature macro: SEQ_GEN_PARITY_EN (adds the PARITY state).
// ---------------------------------------------------------------------------
package seq_gen_pkg;

    localparam int PAT_W_DEF = 8;

`ifdef SEQ_GEN_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/seq_gen_shreg.sv
// ---------------------------------------------------------------------------
// seq_gen_shreg
// Loadable MSB-first shift register with a remaining-bit counter.
// The len window is left-aligned on load so the next bit to send is always
// the register MSB. The latched pattern/len are kept so that a repetition
// can reload the frame without looking at the (possibly changed) inputs.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   load_i       : latch pattern_i/len_i and start a new frame
//   reload_i     : restart the frame from the latched pattern/len
//   shift_i      : advance to the next bit
//   pattern_i    : pattern to serialize
//   len_i        : bit count (0 or > PAT_W means PAT_W)
//   nxt_bit_o    : bit that will be at the MSB after this clock edge
//   last_o       : the bit currently being sent is the last of the frame
// ---------------------------------------------------------------------------
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             reload_i,
    input  logic             shift_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             nxt_bit_o,
    output logic             last_o
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] sr_q, sr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_eff;

    // Zero and oversize lengths both mean "whole register".
    always_comb begin
        len_eff = len_i;
        if (len_i == '0 || len_i > PAT_W_L) begin
            len_eff = PAT_W_L;
        end
    end

    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            pat_d = pattern_i;
            len_d = len_eff;
            sr_d  = pattern_i << (PAT_W_L - len_eff);
            cnt_d = len_eff;
        end else if (reload_i) begin
            sr_d  = pat_q << (PAT_W_L - len_q);
            cnt_d = len_q;
        end else if (shift_i) begin
            sr_d  = sr_q << 1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= '0;
            len_q <= '0;
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign nxt_bit_o = sr_d[PAT_W-1];
    assign last_o    = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// seq_pattern_gen
// Serializes a latched bit pattern MSB-first, repeating it rpt+1 times with
// no gap between frames, then pulses done for one cycle. All outputs are
// registered; the state register reflects what is currently on the outputs.
// Optional feature macro: SEQ_GEN_PARITY_EN appends an even-parity bit
// after each frame (state PARITY).
// Ports:
//   clk     : clock (rising edge)
//   reset   : asynchronous active-high reset
//   start   : begin a transmission (only honoured in IDLE)
//   pattern : bit pattern to send
//   len     : bits per frame, 0 means PAT_W, values > PAT_W clamp to PAT_W
//   rpt     : extra repetitions (frames = rpt+1)
//   a       : serial data bit
//   frame   : a carries a data or parity bit
//   busy    : transmission in progress (through the DONE cycle)
//   done    : one-cycle completion pulse
// ---------------------------------------------------------------------------
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       rpt,
    output logic             a,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    state_t     state_q, state_d;
    logic [3:0] rpt_q, rpt_d;
    logic       a_q, a_d;
    logic       frame_q, frame_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       load, reload, shift;
    logic       nxt_bit, last_bit;
`ifdef SEQ_GEN_PARITY_EN
    logic       par_q, par_d;
`endif

    seq_gen_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .reload_i  (reload),
        .shift_i   (shift),
        .pattern_i (pattern),
        .len_i     (len),
        .nxt_bit_o (nxt_bit),
        .last_o    (last_bit)
    );

    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        a_d     = 1'b0;
        frame_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        reload  = 1'b0;
        shift   = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    rpt_d   = rpt;
                    state_d = SHIFT;
                    a_d     = nxt_bit;
                    frame_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (!last_bit) begin
                    shift   = 1'b1;
                    a_d     = nxt_bit;
                    frame_d = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
                    par_d   = par_q ^ a_q;
`endif
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    // Parity covers every bit of the frame, including the one on a now.
                    state_d = PARITY;
                    a_d     = par_q ^ a_q;
                    frame_d = 1'b1;
`else
                    if (rpt_q != 4'd0) begin
                        reload  = 1'b1;
                        rpt_d   = rpt_q - 4'd1;
                        a_d     = nxt_bit;
                        frame_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: begin
                busy_d = 1'b1;
                if (rpt_q != 4'd0) begin
                    reload  = 1'b1;
                    rpt_d   = rpt_q - 4'd1;
                    state_d = SHIFT;
                    a_d     = nxt_bit;
                    frame_d = 1'b1;
                    par_d   = 1'b0;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
`endif
            DONE: begin
                // A start seen here is dropped; IDLE takes the next one.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rpt_q   <= 4'd0;
            a_q     <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
            a_q     <= a_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_GEN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign a     = a_q;
    assign frame = frame_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_gen
// Scoreboard bench for seq_pattern_gen (PAT_W = 8). Each accepted start
// pushes the expected per-cycle {a, frame, busy, done} sequence; a monitor
// on the falling edge pops and compares, and expects all-zero when idle.
// ---------------------------------------------------------------------------
module tb_seq_pattern_gen;

    localparam int W  = 8;
    localparam int LW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  pattern;
    logic [LW-1:0] len;
    logic [3:0]    rpt;
    logic          a, frame, busy, done;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];
    bit         mon_en   = 1'b0;

    seq_pattern_gen #(.PAT_W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .rpt     (rpt),
        .a       (a),
        .frame   (frame),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Outputs are compared as {a, frame, busy, done}.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                check_eq("stream", 32'({a, frame, busy, done}), 32'(exp_q.pop_front()));
            end else begin
                check_eq("idle", 32'({a, frame, busy, done}), 32'd0);
            end
        end
    end

    task automatic push_txn(input logic [W-1:0] p, input logic [LW-1:0] l, input logic [3:0] r);
        int   n;
        logic par;
        n = (l == 0 || int'(l) > W) ? W : int'(l);
        for (int rep = 0; rep <= int'(r); rep++) begin
            par = 1'b0;
            for (int i = n - 1; i >= 0; i--) begin
                par = par ^ p[i];
                exp_q.push_back({p[i], 1'b1, 1'b1, 1'b0});
            end
`ifdef SEQ_GEN_PARITY_EN
            exp_q.push_back({par, 1'b1, 1'b1, 1'b0});
`endif
        end
        exp_q.push_back(4'b0011);
    endtask

    // Called just after a rising edge with the DUT in IDLE.
    task automatic send(input logic [W-1:0] p, input logic [LW-1:0] l, input logic [3:0] r);
        start   = 1'b1;
        pattern = p;
        len     = l;
        rpt     = r;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pattern = 8'($urandom);
        len     = LW'($urandom);
        rpt     = 4'($urandom);
        push_txn(p, l, r);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            check_eq("timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        rpt     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", 32'({a, frame, busy, done}), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Two-bit window of a mostly-zero pattern.
        send(8'b0000_0010, 4'd2, 4'd0);
        wait_idle();

        // Full width (len=0) with one repetition, back to back.
        send(8'hA5, 4'd0, 4'd1);
        wait_idle();

        // Restart in the very first IDLE cycle after DONE.
        send(8'h3C, 4'd5, 4'd0);
        wait_idle();

        // Second start during the third bit must be ignored.
        send(8'h5C, 4'd8, 4'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start   = 1'b1;
        pattern = 8'hFF;
        len     = 4'd3;
        rpt     = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Start during the DONE cycle must be dropped, not queued.
        send(8'h81, 4'd4, 4'd0);
        begin
            int k = 0;
            while (exp_q.size() != 1 && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
            check_eq("reach_done", 32'(exp_q.size()), 32'd1);
        end
        start   = 1'b1;
        pattern = 8'hF0;
        len     = 4'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        // Asynchronous reset on the fourth bit aborts without done.
        send(8'hFF, 4'd8, 4'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_rst_bit", 32'({a, frame, busy, done}), 32'b1110);
        mon_en = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_async", 32'({a, frame, busy, done}), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("rst_hold", 32'({a, frame, busy, done}), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send(8'hFF, 4'd8, 4'd0);
        wait_idle();

        // Oversize len clamps to the register width.
        send(8'h96, 4'd15, 4'd0);
        wait_idle();

        // Three-bit frame (parity bit appended when enabled).
        send(8'h06, 4'd3, 4'd0);
        wait_idle();

        // Single-bit frames with repetitions.
        send(8'h01, 4'd1, 4'd2);
        wait_idle();

        for (int t = 0; t < 6; t++) begin
            send(8'($urandom), LW'($urandom_range(0, 15)), 4'($urandom_range(0, 2)));
            wait_idle();
        end

        repeat (2) begin
            @(posedge clk);
            #1;
        end
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter PAT_W, default 8: pattern register width in bits, range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-005 pattern  input  PAT_W  bit pattern to serialize; latched on accepted start.
REQ-006 len  input  $clog2(PAT_W)+1  number of pattern bits to send; 0 means PAT_W; latched on accepted start.
REQ-007 rpt  input  4  extra repetitions, so total frames = rpt+1; latched on accepted start.
REQ-008 a  output  1  serial data bit, intended to drive a sequence-detector input.
REQ-009 frame  output  1  high while a carries a valid data or parity bit.
REQ-010 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-011 done  output  1  one-cycle pulse after the final bit of the final frame.

Function
REQ-012 The FSM SHALL use the states IDLE, SHIFT, PARITY and DONE, and all outputs SHALL be registered (Moore).
REQ-013 In IDLE with start=1, the block SHALL latch its inputs and enter SHIFT; the first bit SHALL appear on a exactly 1 cycle later.
REQ-014 In SHIFT, bits SHALL be sent MSB-first within the len window (pattern[len-1] down to pattern[0]), one bit per cycle, with frame=1.
REQ-015 After bit 0 is sent, the FSM SHALL enter PARITY if SEQ_GEN_PARITY_EN is defined; otherwise it SHALL start the next frame or go to DONE.
REQ-016 Between repetitions there SHALL be no gap cycles; the next frame's first bit SHALL follow immediately.
REQ-017 The repetition counter SHALL decrement once per completed frame; when it reaches 0 after the last frame, the FSM SHALL go to DONE.
REQ-018 DONE SHALL last exactly 1 cycle with done=1 and frame=0, then return to IDLE.
REQ-019 In IDLE and DONE, a SHALL be 0 and frame SHALL be 0.
REQ-020 A start asserted while busy=1 or in DONE SHALL be ignored, with no queuing.
REQ-021 The block SHALL accept start again in the first IDLE cycle after DONE.
REQ-022 A len value greater than PAT_W SHALL be clamped to PAT_W.
REQ-023 Changes to pattern, len or rpt during a transmission SHALL have no effect until the next accepted start.

Reset
REQ-024 Asserting reset SHALL immediately force state=IDLE, a=0, frame=0, busy=0, done=0, and clear all counters and latched registers.
REQ-025 A reset asserted mid-frame SHALL abort the transmission without a done pulse; operation SHALL resume normally after reset deasserts.

Configuration
REQ-026 Macro SEQ_GEN_PARITY_EN, when defined, SHALL append one even-parity bit (XOR of the len sent bits) after each frame, with frame=1, in state PARITY.
REQ-027 Without SEQ_GEN_PARITY_EN, the PARITY state and its logic SHALL be absent, and the frame length SHALL be exactly len bits.

Structure
REQ-028 Package seq_gen_pkg SHALL hold the state enum typedef and the default PAT_W constant.
REQ-029 Sub-module seq_gen_shreg (loadable MSB-first shift register with bit counter) SHALL be instantiated once; the FSM SHALL stay in seq_pattern_gen.

Verification
REQ-030 pattern=8'b0000_0010, len=2, rpt=0, no parity -> a=1,0 on cycles 1-2 after start, frame=1 on both, done on cycle 3.
REQ-031 pattern=8'hA5, len=0, rpt=1 -> 16 back-to-back bits 10100101 10100101, then a single done pulse.
REQ-032 start pulsed again at the 3rd bit of a running frame -> no change to the bit stream or the frame count.
REQ-033 reset asserted at the 4th bit of pattern=8'hFF, len=8 -> a, frame and busy drop to 0 at once, no done; a new start sends all 8 bits.
REQ-034 With SEQ_GEN_PARITY_EN, pattern=3'b110, len=3 -> a=1,1,0 then parity bit 0, frame=1 for 4 cycles, then done.
REQ-035 len=15 with PAT_W=8 -> exactly 8 bits are sent.
